// File: rtl/scc_pkg.sv
// Shared types and parameter helpers for the speckle-capture BRAM frame writer.
// Legality helpers are evaluated at elaboration by the top level.
package scc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } scc_state_t;

  function automatic int scc_lanes(input int sample_w);
    return 32 / sample_w;
  endfunction

  function automatic bit scc_sample_w_ok(input int sample_w);
    return sample_w == 8 || sample_w == 16 || sample_w == 32;
  endfunction

  // both ping-pong buffers must fit in the BRAM address space
  function automatic bit scc_frame_ok(input int frame_words,
                                      input int addr_w);
    return frame_words > 0 && (2 * frame_words) <= (1 << addr_w);
  endfunction

endpackage

// File: rtl/scc_sample_packer.sv
// Packs SAMPLE_W-bit samples into 32-bit words, lane 0 in the low bits.
// word_valid/word are combinational on the accept of the last lane.
module scc_sample_packer
  import scc_pkg::*;
#(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic [SAMPLE_W-1:0] data,
  output logic                word_valid,
  output logic [31:0]         word
);

  localparam int LANES = scc_lanes(SAMPLE_W);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  logic [LW-1:0] lane;
  logic [31:0]   acc;

  always_comb begin
    word = acc;
    word[lane*SAMPLE_W +: SAMPLE_W] = data;
  end

  assign word_valid = accept && (lane == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      acc  <= '0;
    end else if (accept) begin
      acc  <= word;
      lane <= (lane == LAST) ? '0 : lane + LW'(1);
    end
  end

endmodule

// File: rtl/scc_bram_frame_writer.sv
// Streams packed sample words into the PL BRAM port, one frame at a time.
// Define SCC_PINGPONG_EN for continuous two-buffer capture with stop/overflow.
module scc_bram_frame_writer
  import scc_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int SAMPLE_W    = 8,
  parameter int FRAME_WORDS = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                irq_ack,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [31:0]         bram_din,
  output logic                bram_en,
  output logic [3:0]          bram_we,
  output logic                irq,
  output logic                irq_buf,
  output logic                busy,
  output logic                overflow
);

  if (!scc_sample_w_ok(SAMPLE_W)) begin : g_bad_sample_w
    $error("scc_bram_frame_writer: SAMPLE_W must be 8, 16 or 32");
  end
  if (!scc_frame_ok(FRAME_WORDS, ADDR_W)) begin : g_bad_frame
    $error("scc_bram_frame_writer: 2*FRAME_WORDS exceeds 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] FW       = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);

  scc_state_t        state;
  scc_state_t        next_state;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] base;
  logic              accept;
  logic              word_valid;
  logic [31:0]       word;
  logic              frame_done;

  assign accept     = s_valid && s_ready;
  assign frame_done = word_valid && (word_idx == LAST_IDX);

  scc_sample_packer #(
    .SAMPLE_W(SAMPLE_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .data      (s_data),
    .word_valid(word_valid),
    .word      (word)
  );

`ifdef SCC_PINGPONG_EN
  logic buf_sel;
  logic stop_seen;
  logic stop_req;

  assign base     = buf_sel ? FW : '0;
  assign stop_req = stop_seen || stop;
`else
  logic unused_stop;

  assign base        = '0;
  assign unused_stop = stop ^ FW[0];
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CAPTURE;
      CAPTURE: begin
        if (frame_done) begin
`ifdef SCC_PINGPONG_EN
          if (stop_req) next_state = IDLE;
`else
          next_state = DONE;
`endif
        end
      end
      DONE:    if (irq_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      bram_en   <= 1'b0;
      bram_we   <= 4'h0;
      bram_addr <= '0;
      bram_din  <= '0;
      word_idx  <= '0;
      irq       <= 1'b0;
    end else begin
      s_ready <= (next_state == CAPTURE);
      busy    <= (next_state != IDLE);
      bram_en <= word_valid;
      bram_we <= word_valid ? 4'hF : 4'h0;
      if (word_valid) begin
        bram_addr <= base + word_idx;
        bram_din  <= word;
      end
      if (state == IDLE && start) word_idx <= '0;
      else if (frame_done)        word_idx <= '0;
      else if (word_valid)        word_idx <= word_idx + ADDR_W'(1);
      // a completion beats a simultaneous acknowledge
      if (frame_done)   irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
    end
  end

`ifdef SCC_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_sel   <= 1'b0;
      stop_seen <= 1'b0;
      irq_buf   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state == IDLE && start) buf_sel <= 1'b0;
      else if (frame_done)        buf_sel <= ~buf_sel;
      if (state != CAPTURE || frame_done) stop_seen <= 1'b0;
      else if (stop)                      stop_seen <= 1'b1;
      if (frame_done) irq_buf <= buf_sel;
      if (frame_done && irq && !irq_ack) overflow <= 1'b1;
    end
  end
`else
  assign irq_buf  = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_scc_bram_frame_writer.sv
// Scoreboard bench for scc_bram_frame_writer (8-bit and 16-bit instances).
// Ping-pong scenarios run when SCC_PINGPONG_EN is defined, single-mode otherwise.
module tb_scc_bram_frame_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        irq_ack = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready8, en8, irq8, irqbuf8, busy8, ovf8;
  logic [7:0]  addr8;
  logic [31:0] din8;
  logic [3:0]  we8;

  logic        start16 = 1'b0;
  logic [15:0] s_data16 = '0;
  logic        s_valid16 = 1'b0;
  logic        s_ready16, en16, irq16, irqbuf16, busy16, ovf16;
  logic [7:0]  addr16;
  logic [31:0] din16;
  logic [3:0]  we16;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  scc_bram_frame_writer #(
    .ADDR_W(8), .SAMPLE_W(8), .FRAME_WORDS(4)
  ) dut8 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .irq_ack(irq_ack), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready8), .bram_addr(addr8), .bram_din(din8),
    .bram_en(en8), .bram_we(we8), .irq(irq8), .irq_buf(irqbuf8),
    .busy(busy8), .overflow(ovf8)
  );

  scc_bram_frame_writer #(
    .ADDR_W(8), .SAMPLE_W(16), .FRAME_WORDS(4)
  ) dut16 (
    .clk(clk), .rst(rst), .start(start16), .stop(stop),
    .irq_ack(irq_ack), .s_data(s_data16), .s_valid(s_valid16),
    .s_ready(s_ready16), .bram_addr(addr16), .bram_din(din16),
    .bram_en(en16), .bram_we(we16), .irq(irq16), .irq_buf(irqbuf16),
    .busy(busy16), .overflow(ovf16)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];

  // scoreboard: every write of dut8 pops one expected write
  always @(negedge clk) begin
    if (en8) begin
      wr_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected got addr=%0h data=%08h cyc=%0d, expected no write",
                 addr8, din8, cyc);
      end else begin
        e = exp_q.pop_front();
        if (addr8 !== e.addr || din8 !== e.data || we8 !== 4'hF ||
            cyc !== e.cyc || (e.last && irq8 !== 1'b1)) begin
          fails++;
          $display("FAIL write got addr=%0h data=%08h we=%h cyc=%0d irq=%b, expected addr=%0h data=%08h we=f cyc=%0d irq=%b",
                   addr8, din8, we8, cyc, irq8, e.addr, e.data, e.cyc, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d, input logic ack);
    s_data  = d;
    s_valid = 1'b1;
    irq_ack = ack;
    tick();
    s_valid = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic send_word8(input logic [7:0] first, input logic [7:0] addr,
                            input logic last, input logic ack);
    logic [7:0] b [4];
    wr_t w;
    for (int i = 0; i < 4; i++) begin
      b[i] = first + 8'(i);
      send8(b[i], ack && i == 3);
    end
    w.addr = addr;
    w.data = {b[3], b[2], b[1], b[0]};
    w.last = last;
    w.cyc  = cyc;
    exp_q.push_back(w);
  endtask

  task automatic send_frame8(input logic [7:0] first, input logic [7:0] base,
                             input logic ack_last);
    for (int w = 0; w < 4; w++)
      send_word8(first + 8'(4 * w), base + 8'(w), w == 3, ack_last && w == 3);
  endtask

  task automatic check_drained(input string name);
    tick();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL %s_drain got %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({s_ready8, en8, we8, addr8, din8, irq8, irqbuf8, busy8, ovf8} !== '0) begin
      fails++;
      $display("FAIL reset8 got rdy=%b en=%b we=%h addr=%h din=%h irq=%b buf=%b busy=%b ovf=%b, expected all 0",
               s_ready8, en8, we8, addr8, din8, irq8, irqbuf8, busy8, ovf8);
    end
    tests++;
    if ({s_ready16, en16, we16, addr16, din16, irq16, irqbuf16, busy16, ovf16} !== '0) begin
      fails++;
      $display("FAIL reset16 got rdy=%b en=%b we=%h addr=%h din=%h irq=%b, expected all 0",
               s_ready16, en16, we16, addr16, din16, irq16);
    end
  endtask

  task automatic test_start_latency();
    do_reset();
    tests++;
    if (s_ready8 !== 1'b0) begin
      fails++;
      $display("FAIL idle_ready got %b, expected 0", s_ready8);
    end
    pulse_start();
    tests++;
    if (s_ready8 !== 1'b1 || busy8 !== 1'b1) begin
      fails++;
      $display("FAIL start_ready got rdy=%b busy=%b, expected 1 1", s_ready8, busy8);
    end
  endtask

  task automatic test_gapped16();
    int a2;
    int found;
    logic [7:0] fa;
    logic [31:0] fd;
    logic [3:0] fw;
    do_reset();
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    s_data16 = 16'h1111;
    s_valid16 = 1'b1;
    tick();
    s_valid16 = 1'b0;
    tests++;
    if (en16 !== 1'b0) begin
      fails++;
      $display("FAIL gap16_early got en=%b, expected 0", en16);
    end
    tick();
    s_data16 = 16'h2222;
    s_valid16 = 1'b1;
    tick();
    s_valid16 = 1'b0;
    a2 = cyc;
    found = -1;
    fa = '0;
    fd = '0;
    fw = '0;
    for (int k = 0; k < 6 && found < 0; k++) begin
      if (en16 === 1'b1) begin
        found = cyc;
        fa = addr16;
        fd = din16;
        fw = we16;
      end else begin
        tick();
      end
    end
    tests++;
    if (found !== a2 || fa !== 8'h00 || fd !== 32'h22221111 || fw !== 4'hF) begin
      fails++;
      $display("FAIL gap16_write got cyc=%0d addr=%0h data=%08h we=%h, expected cyc=%0d addr=0 data=22221111 we=f",
               found, fa, fd, fw, a2);
    end
    tick();
    tests++;
    if (en16 !== 1'b0) begin
      fails++;
      $display("FAIL gap16_pulse got en=%b one cycle later, expected 0", en16);
    end
  endtask

  task automatic test_rst_mid_word();
    do_reset();
    pulse_start();
    send8(8'hAA, 1'b0);
    send8(8'hBB, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (en8 !== 1'b0 || s_ready8 !== 1'b0 || busy8 !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got en=%b rdy=%b busy=%b, expected 0 0 0", en8, s_ready8, busy8);
    end
    pulse_start();
    send_word8(8'h11, 8'h00, 1'b0, 1'b0);
    check_drained("rst_mid");
  endtask

`ifndef SCC_PINGPONG_EN
  task automatic test_single_frame();
    do_reset();
    pulse_start();
    send_frame8(8'h00, 8'h00, 1'b0);
    tests++;
    if (irq8 !== 1'b1 || s_ready8 !== 1'b0 || busy8 !== 1'b1 ||
        irqbuf8 !== 1'b0 || ovf8 !== 1'b0) begin
      fails++;
      $display("FAIL single_done got irq=%b rdy=%b busy=%b buf=%b ovf=%b, expected 1 0 1 0 0",
               irq8, s_ready8, busy8, irqbuf8, ovf8);
    end
    for (int i = 0; i < 4; i++) send8(8'hE0 + 8'(i), 1'b0);
    check_drained("single_hold");
    pulse_ack();
    tests++;
    if (irq8 !== 1'b0 || busy8 !== 1'b0 || s_ready8 !== 1'b0) begin
      fails++;
      $display("FAIL single_ack got irq=%b busy=%b rdy=%b, expected 0 0 0", irq8, busy8, s_ready8);
    end
    pulse_start();
    send_word8(8'h50, 8'h00, 1'b0, 1'b0);
    check_drained("single_restart");
  endtask

  task automatic test_same_cycle_ack();
    do_reset();
    pulse_start();
    send_frame8(8'h40, 8'h00, 1'b1);
    tests++;
    if (irq8 !== 1'b1 || ovf8 !== 1'b0) begin
      fails++;
      $display("FAIL ack_race got irq=%b ovf=%b, expected 1 0", irq8, ovf8);
    end
    check_drained("ack_race");
  endtask
`else
  task automatic test_pp_two_frames();
    do_reset();
    pulse_start();
    send_frame8(8'h00, 8'h00, 1'b0);
    tests++;
    if (irq8 !== 1'b1 || irqbuf8 !== 1'b0 || s_ready8 !== 1'b1) begin
      fails++;
      $display("FAIL pp_frame0 got irq=%b buf=%b rdy=%b, expected 1 0 1", irq8, irqbuf8, s_ready8);
    end
    pulse_ack();
    tests++;
    if (irq8 !== 1'b0 || busy8 !== 1'b1) begin
      fails++;
      $display("FAIL pp_ack got irq=%b busy=%b, expected 0 1", irq8, busy8);
    end
    send_frame8(8'h10, 8'h04, 1'b0);
    tests++;
    if (irq8 !== 1'b1 || irqbuf8 !== 1'b1 || ovf8 !== 1'b0) begin
      fails++;
      $display("FAIL pp_frame1 got irq=%b buf=%b ovf=%b, expected 1 1 0", irq8, irqbuf8, ovf8);
    end
    pulse_ack();
    send_frame8(8'h20, 8'h00, 1'b0);
    tests++;
    if (irqbuf8 !== 1'b0) begin
      fails++;
      $display("FAIL pp_frame2 got buf=%b, expected 0", irqbuf8);
    end
    check_drained("pp_two");
  endtask

  task automatic test_pp_stop();
    do_reset();
    pulse_start();
    send_word8(8'h00, 8'h00, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int w = 1; w < 4; w++)
      send_word8(8'(4 * w), 8'(w), w == 3, 1'b0);
    tests++;
    if (busy8 !== 1'b0 || s_ready8 !== 1'b0 || irq8 !== 1'b1) begin
      fails++;
      $display("FAIL pp_stop got busy=%b rdy=%b irq=%b, expected 0 0 1", busy8, s_ready8, irq8);
    end
    for (int i = 0; i < 4; i++) send8(8'hC0 + 8'(i), 1'b0);
    check_drained("pp_stop");
    pulse_ack();
    pulse_start();
    send_word8(8'h80, 8'h00, 1'b0, 1'b0);
    check_drained("pp_restart");
  endtask

  task automatic test_same_cycle_ack();
    do_reset();
    pulse_start();
    send_frame8(8'h00, 8'h00, 1'b0);
    send_frame8(8'h10, 8'h04, 1'b1);
    tests++;
    if (irq8 !== 1'b1 || ovf8 !== 1'b0) begin
      fails++;
      $display("FAIL ack_race got irq=%b ovf=%b, expected 1 0", irq8, ovf8);
    end
    check_drained("ack_race");
  endtask

  task automatic test_pp_overflow();
    do_reset();
    pulse_start();
    send_frame8(8'h00, 8'h00, 1'b0);
    tests++;
    if (ovf8 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_first got %b, expected 0", ovf8);
    end
    send_frame8(8'h10, 8'h04, 1'b0);
    tests++;
    if (ovf8 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set got %b, expected 1", ovf8);
    end
    pulse_ack();
    tick();
    tests++;
    if (ovf8 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky got %b, expected 1", ovf8);
    end
    check_drained("ovf");
    do_reset();
    tests++;
    if (ovf8 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_rst got %b, expected 0", ovf8);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_latency();
    test_gapped16();
    test_rst_mid_word();
`ifndef SCC_PINGPONG_EN
    test_single_frame();
    test_same_cycle_ack();
`else
    test_pp_two_frames();
    test_pp_stop();
    test_same_cycle_ack();
    test_pp_overflow();
`endif
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
